// File: rtl/led_display_ctrl_if.sv
// Bus bundle between the two requesters, the LED display driver port and the
// shared-port controller.
interface led_display_ctrl_if;
   logic        req0;
   logic        addr0;
   logic [31:0] wd0;
   logic        ack0;
   logic        req1;
   logic [31:0] val1;
   logic [31:0] aux1;
   logic        ack1;
   logic        wb;
   logic        addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        busy;
   logic        err;
   logic [7:0]  errCnt;

   modport master (
      output req0, addr0, wd0, req1, val1, aux1, rd,
      input  ack0, ack1, wb, addr, wd, busy, err, errCnt
   );

   modport slave (
      input  req0, addr0, wd0, req1, val1, aux1, rd,
      output ack0, ack1, wb, addr, wd, busy, err, errCnt
   );
endinterface

// File: rtl/led_display_ctrl.sv
// Round-robin owner of the LED driver write port: CPU single-register writes
// and calculator dual-register writes, each followed by a readback verify.
module led_display_ctrl (
   input  logic              i_clock,
   input  logic              i_reset,
   led_display_ctrl_if.slave io_bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] WR0  = 3'd1;
   localparam logic [2:0] VF0  = 3'd2;
   localparam logic [2:0] WR1  = 3'd3;
   localparam logic [2:0] VF1  = 3'd4;
   localparam logic [2:0] ACK  = 3'd5;

   logic [2:0]  r_state;
   logic        r_last;
   logic        r_grant;
   logic [31:0] r_d0;
   logic [31:0] r_d1;
   logic        r_wb;
   logic        r_addr;
   logic [31:0] r_wd;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_busy;
   logic        r_err;
   logic [7:0]  r_errCnt;

   logic        w_grant0;
   logic        w_grant1;
   logic [2:0]  w_nextState;
   logic        w_grantNext;
   logic [31:0] w_d0Next;
   logic [31:0] w_d1Next;
   logic [31:0] w_wdNext;
   logic        w_mismatch;

   // Ties go to whichever requester was not served last (r_last).
   always_comb begin
      w_grant0    = io_bus.req0 && (!io_bus.req1 || r_last);
      w_grant1    = io_bus.req1 && (!io_bus.req0 || !r_last);
      w_nextState = r_state;
      w_grantNext = r_grant;
      w_d0Next    = r_d0;
      w_d1Next    = r_d1;
      case (r_state)
         IDLE: begin
            if (w_grant0) begin
               w_grantNext = 1'b0;
               w_d0Next    = io_bus.wd0;
               w_d1Next    = io_bus.wd0;
               w_nextState = io_bus.addr0 ? WR1 : WR0;
            end else if (w_grant1) begin
               w_grantNext = 1'b1;
               w_d0Next    = io_bus.val1;
               w_d1Next    = io_bus.aux1;
               w_nextState = WR0;
            end
         end
         WR0:     w_nextState = VF0;
         VF0:     w_nextState = r_grant ? WR1 : ACK;
         WR1:     w_nextState = VF1;
         VF1:     w_nextState = ACK;
         ACK:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase

      case (w_nextState)
         WR0, VF0: w_wdNext = w_d0Next;
         WR1, VF1: w_wdNext = w_d1Next;
         default:  w_wdNext = 32'h0;
      endcase

      // In a verify state r_wd still holds the word that was just written.
      w_mismatch = ((r_state == VF0) || (r_state == VF1)) && (io_bus.rd != r_wd);
   end

   // Outputs are decoded from the next state so they line up with it exactly.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_grant  <= 1'b0;
         r_d0     <= 32'h0;
         r_d1     <= 32'h0;
         r_wb     <= 1'b0;
         r_addr   <= 1'b0;
         r_wd     <= 32'h0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         r_errCnt <= 8'h0;
      end else begin
         r_state <= w_nextState;
         r_grant <= w_grantNext;
         r_d0    <= w_d0Next;
         r_d1    <= w_d1Next;
         if ((r_state == IDLE) && (w_grant0 || w_grant1)) begin
            r_last <= w_grant1;
         end
         r_wb   <= (w_nextState == WR0) || (w_nextState == WR1);
         r_addr <= (w_nextState == WR1) || (w_nextState == VF1);
         r_wd   <= w_wdNext;
         r_ack0 <= (w_nextState == ACK) && !w_grantNext;
         r_ack1 <= (w_nextState == ACK) && w_grantNext;
         r_busy <= (w_nextState != IDLE);
         if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_errCnt != 8'hFF) begin
               r_errCnt <= r_errCnt + 8'd1;
            end
         end
      end
   end

   assign io_bus.wb     = r_wb;
   assign io_bus.addr   = r_addr;
   assign io_bus.wd     = r_wd;
   assign io_bus.ack0   = r_ack0;
   assign io_bus.ack1   = r_ack1;
   assign io_bus.busy   = r_busy;
   assign io_bus.err    = r_err;
   assign io_bus.errCnt = r_errCnt;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Scoreboard bench for led_display_ctrl: stimulus queues expected writes and
// acks, a negedge monitor pops and compares them against the DUT and a driver model.
module tb_led_display_ctrl;

   typedef struct {
      logic        a;
      logic [31:0] d;
   } wrExp_t;

   typedef struct {
      bit          sel;
      int          cyc;
      logic        err;
      logic [7:0]  cnt;
      logic [31:0] r0;
      logic [31:0] r1;
   } ackExp_t;

   logic clock = 1'b0;
   logic reset;
   logic forceZero = 1'b0;
   logic [31:0] drvReg [2] = '{32'h0, 32'h0};
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   wrExp_t  wrQ[$];
   ackExp_t ackQ[$];
   wrExp_t  monW;
   ackExp_t monA;

   led_display_ctrl_if bus();

   led_display_ctrl dut (
      .i_clock (clock),
      .i_reset (reset),
      .io_bus  (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // External LED driver: written on WB edges, RD combinational on Addr.
   always @(posedge clock) begin
      if (bus.wb) drvReg[bus.addr] <= bus.wd;
   end
   assign bus.rd = forceZero ? 32'h0 : drvReg[bus.addr];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual event-missing required event-present (cycle %0d)", name, cyc);
   endtask

   always @(negedge clock) begin
      if (bus.wb) begin
         if (wrQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedWrite actual addr=%0d data=%h required none", bus.addr, bus.wd);
         end else begin
            monW = wrQ.pop_front();
            checkOutput("wrAddr", 32'(bus.addr), 32'(monW.a));
            checkOutput("wrData", bus.wd, monW.d);
         end
      end
      if (bus.ack0 || bus.ack1) begin
         if (ackQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedAck actual ack0=%0d ack1=%0d required none", bus.ack0, bus.ack1);
         end else begin
            monA = ackQ.pop_front();
            checkOutput("ackSel1", 32'(bus.ack1), 32'(monA.sel));
            checkOutput("ackSel0", 32'(bus.ack0), 32'(!monA.sel));
            checkOutput("ackCycle", 32'(cyc), 32'(monA.cyc));
            checkOutput("err", 32'(bus.err), 32'(monA.err));
            checkOutput("errCnt", 32'(bus.errCnt), 32'(monA.cnt));
            checkOutput("drvReg0", drvReg[0], monA.r0);
            checkOutput("drvReg1", drvReg[1], monA.r1);
         end
      end
   end

   task automatic pushAck(input bit sel, input int c, input logic e, input logic [7:0] n,
                          input logic [31:0] r0, input logic [31:0] r1);
      ackExp_t x;
      x.sel = sel; x.cyc = c; x.err = e; x.cnt = n; x.r0 = r0; x.r1 = r1;
      ackQ.push_back(x);
   endtask

   task automatic pushWr(input logic a, input logic [31:0] d);
      wrExp_t x;
      x.a = a; x.d = d;
      wrQ.push_back(x);
   endtask

   // Single-requester transaction; requester holds Req until it sees its Ack.
   task automatic applyStimulus(input bit who, input logic a0, input logic [31:0] dA,
                                input logic [31:0] dB, input logic expErr,
                                input logic [7:0] expCnt, input logic [31:0] r0,
                                input logic [31:0] r1, input bit dropEarly);
      bit done = 1'b0;
      @(negedge clock);
      if (!who) begin
         bus.addr0 = a0;
         bus.wd0   = dA;
         bus.req0  = 1'b1;
         pushWr(a0, dA);
         pushAck(1'b0, cyc + 3, expErr, expCnt, r0, r1);
      end else begin
         bus.val1 = dA;
         bus.aux1 = dB;
         bus.req1 = 1'b1;
         pushWr(1'b0, dA);
         pushWr(1'b1, dB);
         pushAck(1'b1, cyc + 5, expErr, expCnt, r0, r1);
      end
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clock);
         if (dropEarly) bus.req0 = 1'b0;
         if (!who && bus.ack0) begin
            bus.req0 = 1'b0;
            done = 1'b1;
         end
         if (who && bus.ack1) begin
            bus.req1 = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) failNow("ackTimeout");
   endtask

   // Both requesters held high; each drops after its own number of Acks.
   task automatic runBoth(input int want0, input int want1);
      int n0 = 0;
      int n1 = 0;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      for (int i = 0; i < 60 && (n0 < want0 || n1 < want1); i++) begin
         @(negedge clock);
         if (bus.ack0) begin
            n0++;
            if (n0 == want0) bus.req0 = 1'b0;
         end
         if (bus.ack1) begin
            n1++;
            if (n1 == want1) bus.req1 = 1'b0;
         end
      end
      if (n0 < want0 || n1 < want1) begin
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
         failNow("tieTimeout");
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      bus.req0 = 1'b0; bus.addr0 = 1'b0; bus.wd0 = 32'h0;
      bus.req1 = 1'b0; bus.val1 = 32'h0; bus.aux1 = 32'h0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("rstWb", 32'(bus.wb), 32'h0);
      checkOutput("rstAddr", 32'(bus.addr), 32'h0);
      checkOutput("rstWd", bus.wd, 32'h0);
      checkOutput("rstAck0", 32'(bus.ack0), 32'h0);
      checkOutput("rstAck1", 32'(bus.ack1), 32'h0);
      checkOutput("rstBusy", 32'(bus.busy), 32'h0);
      checkOutput("rstErr", 32'(bus.err), 32'h0);
      checkOutput("rstErrCnt", 32'(bus.errCnt), 32'h0);
      reset = 1'b0;

      applyStimulus(1'b0, 1'b0, 32'h12345678, 32'h0, 1'b0, 8'd0, 32'h12345678, 32'h0, 1'b0);
      @(negedge clock);
      checkOutput("idleAfterAck0", 32'(bus.busy), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'hAABBCCDD, 32'hFFFFFFFF, 1'b0, 8'd0, 32'hAABBCCDD, 32'hFFFFFFFF, 1'b0);

      // Tie from reset: grants 0,1,0,1 with one IDLE cycle after every Ack.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.addr0 = 1'b1; bus.wd0 = 32'h000000A5;
      bus.val1 = 32'h0BADF00D; bus.aux1 = 32'h600DCAFE;
      @(negedge clock);
      c = cyc;
      pushWr(1'b1, 32'h000000A5);
      pushWr(1'b0, 32'h0BADF00D);
      pushWr(1'b1, 32'h600DCAFE);
      pushWr(1'b1, 32'h000000A5);
      pushWr(1'b0, 32'h0BADF00D);
      pushWr(1'b1, 32'h600DCAFE);
      pushAck(1'b0, c + 3,  1'b0, 8'd0, 32'hAABBCCDD, 32'h000000A5);
      pushAck(1'b1, c + 9,  1'b0, 8'd0, 32'h0BADF00D, 32'h600DCAFE);
      pushAck(1'b0, c + 13, 1'b0, 8'd0, 32'h0BADF00D, 32'h000000A5);
      pushAck(1'b1, c + 19, 1'b0, 8'd0, 32'h0BADF00D, 32'h600DCAFE);
      runBoth(2, 2);

      // Readback forced to zero: sticky Err, count saturating at 255.
      forceZero = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         applyStimulus(1'b0, 1'b0, 32'h00000001, 32'h0, 1'b1, 8'((k < 255) ? k : 255),
                       32'h00000001, 32'h600DCAFE, 1'b0);
      end
      forceZero = 1'b0;

      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("errCleared", 32'(bus.err), 32'h0);
      checkOutput("errCntCleared", 32'(bus.errCnt), 32'h0);

      // Reset lands on the edge ending VF0 of a requester 1 transaction.
      @(negedge clock);
      bus.val1 = 32'h77777777; bus.aux1 = 32'h88888888;
      bus.req1 = 1'b1;
      pushWr(1'b0, 32'h77777777);
      @(negedge clock);
      @(negedge clock);
      checkOutput("vf0Busy", 32'(bus.busy), 32'h1);
      checkOutput("vf0Wb", 32'(bus.wb), 32'h0);
      reset = 1'b1;
      bus.req1 = 1'b0;
      forceZero = 1'b1;
      @(negedge clock);
      forceZero = 1'b0;
      checkOutput("midRstWb", 32'(bus.wb), 32'h0);
      checkOutput("midRstBusy", 32'(bus.busy), 32'h0);
      checkOutput("midRstAck1", 32'(bus.ack1), 32'h0);
      checkOutput("midRstErr", 32'(bus.err), 32'h0);
      checkOutput("midRstWd", bus.wd, 32'h0);
      reset = 1'b0;

      // Pointer must be back to "last = 1": requester 0 wins this tie.
      @(negedge clock);
      c = cyc;
      bus.addr0 = 1'b0; bus.wd0 = 32'h0F0F0F0F;
      bus.val1 = 32'h01020304; bus.aux1 = 32'h05060708;
      pushWr(1'b0, 32'h0F0F0F0F);
      pushWr(1'b0, 32'h01020304);
      pushWr(1'b1, 32'h05060708);
      pushAck(1'b0, c + 3, 1'b0, 8'd0, 32'h0F0F0F0F, 32'h600DCAFE);
      pushAck(1'b1, c + 9, 1'b0, 8'd0, 32'h01020304, 32'h05060708);
      runBoth(1, 1);

      applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 8'd0, 32'h01020304, 32'hDEADBEEF, 1'b1);
      repeat (4) @(negedge clock);
      checkOutput("noRetrigger", 32'(bus.busy), 32'h0);

      repeat (2) @(negedge clock);
      checkOutput("ackQEmpty", 32'(ackQ.size()), 32'h0);
      checkOutput("wrQEmpty", 32'(wrQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_display_ctrl.md
# led_display_ctrl

Bus-side controller that shares the write port of the LED display driver between two requesters. Requester 0 is the CPU bridge, which writes a single register. Requester 1 is the calculator FSM, which updates both registers atomically. Each write is followed by a readback-verify cycle. The block sits between those masters and the driver's WB/Addr/WD/RD port, and it is the only agent that drives that port.

## Interface
- No parameters.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Req0  in  1  CPU request; held high until Ack0.
- Addr0  in  1  CPU target register: 0 = digit word (8 tubes), 1 = aux word (single tube).
- WD0  in  32  CPU write data.
- Ack0  out  1  one-cycle completion pulse for requester 0.
- Req1  in  1  calculator request; held high until Ack1.
- Val1  in  32  calculator digit word, written to register 0.
- Aux1  in  32  calculator aux word, written to register 1.
- Ack1  out  1  one-cycle completion pulse for requester 1.
- WB  out  1  driver write enable.
- Addr  out  1  driver register select; drives the driver's Addr[2:2].
- WD  out  32  driver write data.
- RD  in  32  driver read data; combinational function of Addr.
- Busy  out  1  high in every state except IDLE.
- Err  out  1  sticky readback-mismatch flag.
- ErrCnt  out  8  mismatch count; saturates at 255.

## Operation
- Driver contract: the register is written at a rising edge where WB=1. RD shows the register selected by the current Addr in the same cycle.
- States: IDLE, WR0, VF0, WR1, VF1, ACK.
- IDLE samples Req0/Req1. It then latches the granted requester's data into internal registers: D0/D1 and, for requester 0, the target Addr0. Requests are sampled only in IDLE.
- Requester 0 path: IDLE -> WRx -> VFx -> ACK -> IDLE. WRx/VFx is WR0/VF0 if the latched Addr0=0, else WR1/VF1.
- Requester 1 path: IDLE -> WR0 -> VF0 -> WR1 -> VF1 -> ACK -> IDLE.
- WRn: WB=1, Addr=n, WD=latched word.
- VFn: WB=0, Addr=n, WD=latched word. The block compares RD against the latched word.
  - On mismatch: Err <= 1 and ErrCnt <= ErrCnt+1, saturating at 255.
  - The transaction continues regardless; there is no retry.
- ACK: pulse Ack of the granted requester for exactly one cycle.
- Arbitration is round-robin using a last-served pointer.
  - Only one requester active: it is granted.
  - Both active: the requester not served last is granted.
  - After reset the pointer is "last = 1", so requester 0 wins the first tie.
- Deasserting Req mid-transaction is ignored; the transaction completes and Ack still pulses.
- If Req is still high in the cycle after Ack, that is a new request, sampled in IDLE.
- In IDLE and ACK: WB=0, Addr=0, WD=0.

## Timing
- Reset values:
  - State=IDLE, pointer=1.
  - WB=0, Addr=0, WD=0.
  - Ack0=0, Ack1=0, Busy=0, Err=0, ErrCnt=0.
- Reset asserted mid-transaction: at the next edge the block returns to IDLE with all of the above values. No Ack is issued. A partially written driver is not rolled back.
- All outputs are registered from state and latched data. Err/ErrCnt update at the edge ending VFn.
- Requester 0 latency: with Req0 sampled at edge t:
  - WB=1 during cycle t..t+1.
  - Verify during t+1..t+2.
  - Ack0 during t+2..t+3.
  - Back in IDLE at t+3.
- Requester 1 latency: Ack1 is asserted 4 cycles after the grant edge.
  - WR0 occupies 1 cycle, VF0 1, WR1 1, VF1 1, then ACK.
- Minimum spacing between grants: requester 0 = 4 cycles, requester 1 = 6 cycles. One IDLE cycle always separates transactions.
- Simultaneous new requests while Busy are held off until IDLE. Requesters must keep Req high until their Ack.

## Test plan
- Reset, then Req0=1, Addr0=0, WD0=32'h12345678 -> WB=1/Addr=0/WD=12345678 for 1 cycle, then 1 verify cycle, then Ack0 pulse 3 cycles after grant; Err=0.
- Req1=1, Val1=32'haabbccdd, Aux1=32'hffffffff -> WR0(aabbccdd), VF0, WR1(ffffffff), VF1, then Ack1 pulse; driver RD at Addr=1 reads ffffffff.
- Req0 and Req1 both high from reset and held -> grant order 0, 1, 0, 1. Each Ack is followed by one IDLE cycle.
- Bench forces RD=0 during VF0 with WD=32'h00000001 -> Err=1 and ErrCnt=1; Ack still issued. 256 forced mismatches leave ErrCnt=255.
- Reset asserted during VF0 of a requester 1 transaction -> next cycle State=IDLE, WB=0, no Ack1, Err unchanged from 0, pointer=1.
- Req0 dropped during WR0 -> Ack0 still pulses on schedule; no second transaction starts.
